bsg_activation_rr_sched: RTL and testbench
==========================================

# bsg_activation_rr_sched

Round-robin scheduler that shares one iterative activation unit (e.g. the CORDIC/divider tanh unit) among `num_req_p` requesters. It accepts one angle at a time, issues it to the unit, captures the unit's result, and routes the result back to the requester that issued it. The block sits between requesting datapath lanes and a single non-pipelined activation unit. It allows exactly one operation in flight.

## Interface
- `num_req_p`, 4, number of requesters (2..16).
- `ang_width_p`, 21, signed angle width.
- `ans_width_p`, 32, signed result width.
- `cnt_width_p`, 16, width of the completed-operation counter.

Ports:
- `clk_i` in 1: single clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `req_v_i` in `num_req_p`: per-requester request valid.
- `req_ang_i` in `num_req_p*ang_width_p`: packed angles; requester i occupies bits `[i*ang_width_p +: ang_width_p]`.
- `req_ready_o` out `num_req_p`: one-hot accept; at most one bit set.
- `res_v_o` out `num_req_p`: one-hot result valid for the owning requester.
- `res_o` out `ans_width_p`: result data, shared by all requesters.
- `res_yumi_i` in `num_req_p`: per-requester result consume.
- `unit_v_o` out 1: request valid to the activation unit.
- `unit_ang_o` out `ang_width_p`: angle to the unit.
- `unit_ready_i` in 1: unit can accept.
- `unit_v_i` in 1: unit result valid.
- `unit_res_i` in `ans_width_p`: unit result.
- `unit_yumi_o` out 1: consume unit result (drives the unit's `ready_i`).
- `busy_o` out 1: an operation is owned by the scheduler (state is not eIDLE).
- `done_cnt_o` out `cnt_width_p`: number of results delivered; wraps.

## Operation
- States: eIDLE, eISSUE, eWAIT, eRETURN. Registers: `state_r`, `ptr_r` (`$clog2(num_req_p)` bits), `tag_r`, `ang_r`, `res_r`, `done_cnt_r`.
- **eIDLE**
  - Grant = the first asserted `req_v_i` bit searching upward from `ptr_r`, wrapping modulo `num_req_p`.
  - `req_ready_o` = the one-hot grant. It is combinational from `req_v_i` and `ptr_r`.
  - On a grant, latch `ang_r` = the granted angle and `tag_r` = the granted index. Set `ptr_r` = (index+1) mod `num_req_p`. Go to eISSUE.
  - No grant: stay in eIDLE; `ptr_r` is unchanged.
- **eISSUE**
  - Drive `unit_v_o`=1 and `unit_ang_o`=`ang_r`.
  - When `unit_ready_i`=1 (handshake), go to eWAIT. Otherwise hold all values.
- **eWAIT**
  - `unit_yumi_o`=`unit_v_i`.
  - When `unit_v_i`=1: capture `res_r`=`unit_res_i` and go to eRETURN. The unit is released in that same cycle.
- **eRETURN**
  - `res_v_o`=one-hot(`tag_r`) and `res_o`=`res_r`.
  - When `res_yumi_i[tag_r]`=1: increment `done_cnt_r` (wraps to 0 at the maximum value) and go to eIDLE.
  - `res_yumi_i` bits other than `tag_r` are ignored.
- `unit_ang_o` always equals `ang_r`. `res_o` always equals `res_r`.
- Data is passed through unmodified; the block performs no arithmetic on angles or results.

## Timing
- Reset (`reset_n_i`=0, asynchronous) sets:
  - state eIDLE;
  - `ptr_r`, `tag_r`, `ang_r`, `res_r`, `done_cnt_r` = 0;
  - outputs `unit_v_o`, `unit_yumi_o`, `res_v_o`, `busy_o` = 0; `done_cnt_o` = 0.
  - `req_ready_o` follows the eIDLE rule as soon as reset is released.
- Reset asserted mid-operation aborts the operation and discards the in-flight result. The activation unit must be reset in the same event.
- Accept to `unit_v_o`: 1 cycle.
- Unit result to `res_v_o`: 1 cycle.
- Result consume to next accept: 1 cycle, because eIDLE is entered on the next edge.
- Minimum overhead per operation is 4 cycles plus the unit latency.
- `unit_v_o` stays high until the handshake. `res_v_o` stays high until yumi. Neither output ever drops without its handshake.
- A requester whose `req_v_i` falls before it is granted is simply not granted.
- Starvation-free: any requester holding `req_v_i` high is granted within `num_req_p` operations.

## Test plan
- **Single request.** Reset, then `req_v_i`=4'b0100 with angle 21'sd1000; unit is ready immediately and returns 32'h0000_1234 after 10 cycles.
  - `req_ready_o`=4'b0100 in the same cycle; `unit_v_o` the next cycle.
  - `res_v_o`=4'b0100 with `res_o`=32'h0000_1234 one cycle after `unit_v_i`.
  - `done_cnt_o`=1 after yumi.
- **Round robin.** All four `req_v_i` held high.
  - Grant order is 0,1,2,3,0.
  - Each result appears only on its own tag's `res_v_o` bit.
- **Backpressure.** Hold `unit_ready_i`=0 for 5 cycles, then hold `res_yumi_i`=0 for 3 cycles.
  - `unit_v_o` and `unit_ang_o` stay stable for the full stall.
  - `res_v_o` and `res_o` stay stable until yumi arrives.
  - No new grant is issued while busy.
- **Wrong yumi.** In eRETURN with tag 1, assert `res_yumi_i`=4'b0001.
  - State stays eRETURN and `done_cnt_o` is unchanged.
  - Asserting bit 1 then completes the operation.
- **Mid-op reset.** Assert `reset_n_i`=0 asynchronously (between clock edges) while in eWAIT.
  - All outputs read 0 immediately.
  - After release, a fresh request to requester 0 is granted first (`ptr_r`=0).
- **Counter wrap.** With `cnt_width_p`=2, complete 5 operations; `done_cnt_o` reads 1.

Source files
------------

// File: rtl/bsg_activation_rr_sched_if.sv
// Handshake bundle between the requesting lanes, the shared activation unit
// and the round-robin scheduler.
interface bsg_activation_rr_sched_if #(
    parameter int num_req_p   = 4,
    parameter int ang_width_p = 21,
    parameter int ans_width_p = 32
);
    logic [num_req_p-1:0]             req_v_i;
    logic [num_req_p*ang_width_p-1:0] req_ang_i;
    logic [num_req_p-1:0]             req_ready_o;
    logic [num_req_p-1:0]             res_v_o;
    logic [ans_width_p-1:0]           res_o;
    logic [num_req_p-1:0]             res_yumi_i;
    logic                             unit_v_o;
    logic [ang_width_p-1:0]           unit_ang_o;
    logic                             unit_ready_i;
    logic                             unit_v_i;
    logic [ans_width_p-1:0]           unit_res_i;
    logic                             unit_yumi_o;

    modport slave (
        input  req_v_i, req_ang_i, res_yumi_i, unit_ready_i, unit_v_i, unit_res_i,
        output req_ready_o, res_v_o, res_o, unit_v_o, unit_ang_o, unit_yumi_o
    );

    modport master (
        output req_v_i, req_ang_i, res_yumi_i, unit_ready_i, unit_v_i, unit_res_i,
        input  req_ready_o, res_v_o, res_o, unit_v_o, unit_ang_o, unit_yumi_o
    );
endinterface

// File: rtl/bsg_activation_rr_sched.sv
// Round-robin sharing of one non-pipelined activation unit among num_req_p lanes;
// exactly one operation is in flight at a time.
//
// state    | meaning
// e_idle   | arbitrate among req_v_i starting at ptr_r
// e_issue  | present ang_r to the unit until it accepts
// e_wait   | wait for the unit result, consume it on arrival
// e_return | present res_r to requester tag_r until it yumis
module bsg_activation_rr_sched #(
    parameter int num_req_p   = 4,
    parameter int ang_width_p = 21,
    parameter int ans_width_p = 32,
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    bsg_activation_rr_sched_if.slave bus,
    output logic                   busy_o,
    output logic [cnt_width_p-1:0] done_cnt_o
);
    localparam int ptr_w_lp = $clog2(num_req_p);

    localparam logic [1:0] e_idle   = 2'd0;
    localparam logic [1:0] e_issue  = 2'd1;
    localparam logic [1:0] e_wait   = 2'd2;
    localparam logic [1:0] e_return = 2'd3;

    localparam logic [ptr_w_lp:0]   num_req_lp  = (ptr_w_lp+1)'(num_req_p);
    localparam logic [ptr_w_lp-1:0] last_idx_lp = ptr_w_lp'(num_req_p - 1);

    logic [1:0]             state_r;
    logic [ptr_w_lp-1:0]    ptr_r;
    logic [ptr_w_lp-1:0]    tag_r;
    logic [ang_width_p-1:0] ang_r;
    logic [ans_width_p-1:0] res_r;
    logic [cnt_width_p-1:0] done_cnt_r;

    logic [ang_width_p-1:0] ang_a [num_req_p];
    logic [ptr_w_lp:0]      cand;
    logic                   grant_v;
    logic [ptr_w_lp-1:0]    grant_idx;
    logic [num_req_p-1:0]   req_ready;
    logic [num_req_p-1:0]   res_v;

    for (genvar g = 0; g < num_req_p; g++) begin : g_unpack
        assign ang_a[g] = bus.req_ang_i[g*ang_width_p +: ang_width_p];
    end

    // Search upward from ptr_r; cand stays below 2*num_req_p so one subtract wraps it.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = {1'b0, ptr_r} + (ptr_w_lp+1)'(i);
            if (cand >= num_req_lp) cand = cand - num_req_lp;
            if (!grant_v && bus.req_v_i[cand[ptr_w_lp-1:0]]) begin
                grant_v   = 1'b1;
                grant_idx = cand[ptr_w_lp-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_r == e_idle && grant_v) req_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        res_v = '0;
        if (state_r == e_return) res_v[tag_r] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_idle;
            ptr_r      <= '0;
            tag_r      <= '0;
            ang_r      <= '0;
            res_r      <= '0;
            done_cnt_r <= '0;
        end else begin
            case (state_r)
                e_idle: begin
                    if (grant_v) begin
                        ang_r   <= ang_a[grant_idx];
                        tag_r   <= grant_idx;
                        ptr_r   <= (grant_idx == last_idx_lp) ? '0 : grant_idx + 1'b1;
                        state_r <= e_issue;
                    end
                end
                e_issue: begin
                    if (bus.unit_ready_i) state_r <= e_wait;
                end
                e_wait: begin
                    if (bus.unit_v_i) begin
                        res_r   <= bus.unit_res_i;
                        state_r <= e_return;
                    end
                end
                e_return: begin
                    if (bus.res_yumi_i[tag_r]) begin
                        done_cnt_r <= done_cnt_r + 1'b1;
                        state_r    <= e_idle;
                    end
                end
                default: state_r <= e_idle;
            endcase
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.res_v_o     = res_v;
    assign bus.res_o       = res_r;
    assign bus.unit_v_o    = (state_r == e_issue);
    assign bus.unit_ang_o  = ang_r;
    assign bus.unit_yumi_o = (state_r == e_wait) && bus.unit_v_i;
    assign busy_o          = (state_r != e_idle);
    assign done_cnt_o      = done_cnt_r;
endmodule

// File: tb/tb_bsg_activation_rr_sched.sv
// Bench for bsg_activation_rr_sched: a second instance with a 2-bit counter
// shadows the first on identical stimulus to exercise counter wrap.
module tb_bsg_activation_rr_sched;
    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        busy1, busy2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ptr_m     = 0;
    int cnt_m     = 0;

    bsg_activation_rr_sched_if #(.num_req_p(4), .ang_width_p(21), .ans_width_p(32)) u1 ();
    bsg_activation_rr_sched_if #(.num_req_p(4), .ang_width_p(21), .ans_width_p(32)) u2 ();

    assign u2.req_v_i      = u1.req_v_i;
    assign u2.req_ang_i    = u1.req_ang_i;
    assign u2.res_yumi_i   = u1.res_yumi_i;
    assign u2.unit_ready_i = u1.unit_ready_i;
    assign u2.unit_v_i     = u1.unit_v_i;
    assign u2.unit_res_i   = u1.unit_res_i;

    bsg_activation_rr_sched #(.num_req_p(4), .ang_width_p(21), .ans_width_p(32), .cnt_width_p(16)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(u1.slave), .busy_o(busy1), .done_cnt_o(cnt1));

    bsg_activation_rr_sched #(.num_req_p(4), .ang_width_p(21), .ans_width_p(32), .cnt_width_p(2)) dut_wrap (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(u2.slave), .busy_o(busy2), .done_cnt_o(cnt2));

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_n_i       = 1'b0;
        u1.req_v_i      = '0;
        u1.req_ang_i    = '0;
        u1.res_yumi_i   = '0;
        u1.unit_ready_i = 1'b0;
        u1.unit_v_i     = 1'b0;
        u1.unit_res_i   = '0;
        #7;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();
        ptr_m = 0;
        cnt_m = 0;
    endtask

    // Reference arbiter: first requester at or after ptr_m, modulo 4.
    function automatic int model_pick(input logic [3:0] v);
        for (int k = 0; k < 4; k++)
            if (v[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        return -1;
    endfunction

    function automatic logic [83:0] rand_angs();
        logic [83:0] a;
        for (int k = 0; k < 4; k++) a[k*21 +: 21] = 21'($urandom);
        return a;
    endfunction

    // Drives one complete operation and reports what it observed; entered idle at posedge+1.
    task automatic do_op(input logic [3:0] v, input logic [83:0] angs, input int rdy_dly,
                         input int lat, input int yumi_dly, input logic [31:0] ures,
                         output logic [3:0] grant, output logic [20:0] ang_seen,
                         output logic issue_ok, output logic idle_hold, output logic yumi_seen,
                         output logic [3:0] resv_seen, output logic [31:0] res_seen,
                         output logic ret_ok);
        u1.req_v_i   = v;
        u1.req_ang_i = angs;
        #1;
        grant     = u1.req_ready_o;
        ang_seen  = '0;
        issue_ok  = 1'b0;
        idle_hold = 1'b1;
        yumi_seen = 1'b0;
        resv_seen = '0;
        res_seen  = '0;
        ret_ok    = 1'b0;
        if (grant == 4'b0) begin
            u1.req_v_i = '0;
            return;
        end
        step();
        u1.req_v_i = 4'hF;
        #1;
        ang_seen  = u1.unit_ang_o;
        issue_ok  = u1.unit_v_o;
        idle_hold = (u1.req_ready_o === 4'b0);
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            issue_ok  &= (u1.unit_v_o === 1'b1) && (u1.unit_ang_o === ang_seen);
            idle_hold &= (u1.req_ready_o === 4'b0);
        end
        u1.unit_ready_i = 1'b1;
        step();
        u1.unit_ready_i = 1'b0;
        for (int i = 0; i < lat; i++) begin
            step();
            idle_hold &= (u1.req_ready_o === 4'b0);
        end
        u1.unit_v_i   = 1'b1;
        u1.unit_res_i = ures;
        #1;
        yumi_seen = u1.unit_yumi_o;
        step();
        u1.unit_v_i = 1'b0;
        resv_seen   = u1.res_v_o;
        res_seen    = u1.res_o;
        ret_ok      = 1'b1;
        idle_hold  &= (u1.req_ready_o === 4'b0);
        for (int i = 0; i < yumi_dly; i++) begin
            step();
            ret_ok    &= (u1.res_v_o === resv_seen) && (u1.res_o === res_seen);
            idle_hold &= (u1.req_ready_o === 4'b0);
        end
        u1.res_yumi_i = resv_seen;
        step();
        u1.res_yumi_i = '0;
        u1.req_v_i    = '0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        u1.req_v_i = '0; u1.req_ang_i = '0; u1.res_yumi_i = '0;
        u1.unit_ready_i = 1'b0; u1.unit_v_i = 1'b0; u1.unit_res_i = '0;
        #3;
        total_cnt++; if (u1.unit_v_o !== 1'b0) $display("FAIL reset_unit_v got %b want 0", u1.unit_v_o); else pass_cnt++;
        total_cnt++; if (u1.unit_yumi_o !== 1'b0) $display("FAIL reset_unit_yumi got %b want 0", u1.unit_yumi_o); else pass_cnt++;
        total_cnt++; if (u1.res_v_o !== 4'b0) $display("FAIL reset_res_v got %b want 0000", u1.res_v_o); else pass_cnt++;
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL reset_busy got %b want 0", busy1); else pass_cnt++;
        total_cnt++; if (cnt1 !== 16'd0) $display("FAIL reset_cnt got %0d want 0", cnt1); else pass_cnt++;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();
        u1.req_v_i = 4'b0010;
        #1;
        total_cnt++; if (u1.req_ready_o !== 4'b0010) $display("FAIL reset_first_grant got %b want 0010", u1.req_ready_o); else pass_cnt++;
        u1.req_v_i = '0;
        step();
        ptr_m = 0;
        cnt_m = 0;
    endtask

    task automatic test_single();
        logic [3:0] g, rv; logic [20:0] a; logic [31:0] r; logic iok, ih, y, rok;
        logic [83:0] angs;
        angs = '0;
        angs[2*21 +: 21] = 21'sd1000;
        do_op(4'b0100, angs, 0, 10, 0, 32'h0000_1234, g, a, iok, ih, y, rv, r, rok);
        total_cnt++; if (g !== 4'b0100) $display("FAIL single_grant got %b want 0100", g); else pass_cnt++;
        total_cnt++; if (a !== 21'sd1000) $display("FAIL single_unit_ang got %0d want 1000", a); else pass_cnt++;
        total_cnt++; if (iok !== 1'b1) $display("FAIL single_unit_v got %b want 1", iok); else pass_cnt++;
        total_cnt++; if (y !== 1'b1) $display("FAIL single_unit_yumi got %b want 1", y); else pass_cnt++;
        total_cnt++; if (rv !== 4'b0100) $display("FAIL single_res_v got %b want 0100", rv); else pass_cnt++;
        total_cnt++; if (r !== 32'h0000_1234) $display("FAIL single_res got %h want 00001234", r); else pass_cnt++;
        total_cnt++; if (cnt1 !== 16'd1) $display("FAIL single_done_cnt got %0d want 1", cnt1); else pass_cnt++;
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL single_idle_after got %b want 0", busy1); else pass_cnt++;
        ptr_m = 3;
        cnt_m = 1;
    endtask

    task automatic test_round_robin();
        logic [3:0] g, rv, exp_oh; logic [20:0] a; logic [31:0] r, ures; logic iok, ih, y, rok;
        logic [83:0] angs;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            angs   = rand_angs();
            ures   = $urandom;
            exp_oh = 4'b0001 << (k % 4);
            do_op(4'hF, angs, 0, 2, 0, ures, g, a, iok, ih, y, rv, r, rok);
            total_cnt++; if (g !== exp_oh) $display("FAIL rr_grant[%0d] got %b want %b", k, g, exp_oh); else pass_cnt++;
            total_cnt++; if (a !== angs[(k%4)*21 +: 21]) $display("FAIL rr_ang[%0d] got %h want %h", k, a, angs[(k%4)*21 +: 21]); else pass_cnt++;
            total_cnt++; if (rv !== exp_oh) $display("FAIL rr_res_v[%0d] got %b want %b", k, rv, exp_oh); else pass_cnt++;
            total_cnt++; if (r !== ures) $display("FAIL rr_res[%0d] got %h want %h", k, r, ures); else pass_cnt++;
            ptr_m = (k % 4 + 1) % 4;
            cnt_m++;
        end
        total_cnt++; if (cnt1 !== 16'(cnt_m)) $display("FAIL rr_done_cnt got %0d want %0d", cnt1, cnt_m); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [3:0] g, rv, v, exp_oh; logic [20:0] a; logic [31:0] r, ures; logic iok, ih, y, rok;
        logic [83:0] angs;
        int idx;
        v      = 4'($urandom_range(1, 15));
        angs   = rand_angs();
        ures   = $urandom;
        idx    = model_pick(v);
        exp_oh = 4'b0001 << idx;
        do_op(v, angs, 5, 3, 3, ures, g, a, iok, ih, y, rv, r, rok);
        total_cnt++; if (g !== exp_oh) $display("FAIL bp_grant got %b want %b", g, exp_oh); else pass_cnt++;
        total_cnt++; if (a !== angs[idx*21 +: 21]) $display("FAIL bp_ang got %h want %h", a, angs[idx*21 +: 21]); else pass_cnt++;
        total_cnt++; if (iok !== 1'b1) $display("FAIL bp_issue_stable got %b want 1", iok); else pass_cnt++;
        total_cnt++; if (rok !== 1'b1) $display("FAIL bp_return_stable got %b want 1", rok); else pass_cnt++;
        total_cnt++; if (ih !== 1'b1) $display("FAIL bp_no_grant_busy got %b want 1", ih); else pass_cnt++;
        total_cnt++; if (r !== ures) $display("FAIL bp_res got %h want %h", r, ures); else pass_cnt++;
        ptr_m = (idx + 1) % 4;
        cnt_m++;
        total_cnt++; if (cnt1 !== 16'(cnt_m)) $display("FAIL bp_done_cnt got %0d want %0d", cnt1, cnt_m); else pass_cnt++;
    endtask

    task automatic test_wrong_yumi();
        logic [31:0] ures;
        ures = $urandom;
        u1.req_v_i   = 4'b0010;
        u1.req_ang_i = rand_angs();
        #1;
        total_cnt++; if (u1.req_ready_o !== 4'b0010) $display("FAIL wy_grant got %b want 0010", u1.req_ready_o); else pass_cnt++;
        step();
        u1.req_v_i = '0;
        u1.unit_ready_i = 1'b1;
        step();
        u1.unit_ready_i = 1'b0;
        u1.unit_v_i     = 1'b1;
        u1.unit_res_i   = ures;
        step();
        u1.unit_v_i   = 1'b0;
        u1.res_yumi_i = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++; if (u1.res_v_o !== 4'b0010) $display("FAIL wy_res_v_held[%0d] got %b want 0010", i, u1.res_v_o); else pass_cnt++;
            total_cnt++; if (cnt1 !== 16'(cnt_m)) $display("FAIL wy_cnt_held[%0d] got %0d want %0d", i, cnt1, cnt_m); else pass_cnt++;
        end
        u1.res_yumi_i = 4'b0010;
        step();
        u1.res_yumi_i = '0;
        cnt_m++;
        ptr_m = 2;
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL wy_complete_busy got %b want 0", busy1); else pass_cnt++;
        total_cnt++; if (cnt1 !== 16'(cnt_m)) $display("FAIL wy_complete_cnt got %0d want %0d", cnt1, cnt_m); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        u1.req_v_i   = 4'b1000;
        u1.req_ang_i = rand_angs();
        step();
        u1.req_v_i = '0;
        u1.unit_ready_i = 1'b1;
        step();
        u1.unit_ready_i = 1'b0;
        step();
        total_cnt++; if (busy1 !== 1'b1) $display("FAIL mr_busy_before got %b want 1", busy1); else pass_cnt++;
        #2;
        u1.unit_v_i = 1'b1;
        reset_n_i   = 1'b0;
        #1;
        total_cnt++; if (u1.unit_yumi_o !== 1'b0) $display("FAIL mr_unit_yumi got %b want 0", u1.unit_yumi_o); else pass_cnt++;
        total_cnt++; if (u1.unit_v_o !== 1'b0) $display("FAIL mr_unit_v got %b want 0", u1.unit_v_o); else pass_cnt++;
        total_cnt++; if (u1.res_v_o !== 4'b0) $display("FAIL mr_res_v got %b want 0000", u1.res_v_o); else pass_cnt++;
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL mr_busy got %b want 0", busy1); else pass_cnt++;
        total_cnt++; if (cnt1 !== 16'd0) $display("FAIL mr_cnt got %0d want 0", cnt1); else pass_cnt++;
        u1.unit_v_i = 1'b0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        step();
        ptr_m = 0;
        cnt_m = 0;
        u1.req_v_i = 4'hF;
        #1;
        total_cnt++; if (u1.req_ready_o !== 4'b0001) $display("FAIL mr_first_grant got %b want 0001", u1.req_ready_o); else pass_cnt++;
        u1.req_v_i = '0;
        step();
    endtask

    task automatic test_random();
        logic [3:0] g, rv, v, exp_oh; logic [20:0] a; logic [31:0] r, ures; logic iok, ih, y, rok;
        logic [83:0] angs;
        int idx;
        for (int k = 0; k < 20; k++) begin
            v      = 4'($urandom_range(1, 15));
            angs   = rand_angs();
            ures   = $urandom;
            idx    = model_pick(v);
            exp_oh = 4'b0001 << idx;
            do_op(v, angs, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2), ures,
                  g, a, iok, ih, y, rv, r, rok);
            ptr_m = (idx + 1) % 4;
            cnt_m++;
            total_cnt++; if (g !== exp_oh) $display("FAIL rnd_grant[%0d] got %b want %b", k, g, exp_oh); else pass_cnt++;
            total_cnt++; if (a !== angs[idx*21 +: 21]) $display("FAIL rnd_ang[%0d] got %h want %h", k, a, angs[idx*21 +: 21]); else pass_cnt++;
            total_cnt++; if (rv !== exp_oh) $display("FAIL rnd_res_v[%0d] got %b want %b", k, rv, exp_oh); else pass_cnt++;
            total_cnt++; if (r !== ures) $display("FAIL rnd_res[%0d] got %h want %h", k, r, ures); else pass_cnt++;
            total_cnt++; if (cnt1 !== 16'(cnt_m)) $display("FAIL rnd_cnt[%0d] got %0d want %0d", k, cnt1, cnt_m); else pass_cnt++;
        end
    endtask

    task automatic test_counter_wrap();
        logic [3:0] g, rv; logic [20:0] a; logic [31:0] r; logic iok, ih, y, rok;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            do_op(4'($urandom_range(1, 15)), rand_angs(), 0, 1, 0, $urandom, g, a, iok, ih, y, rv, r, rok);
            cnt_m++;
        end
        total_cnt++; if (cnt2 !== 2'd1) $display("FAIL wrap_cnt2 got %0d want 1", cnt2); else pass_cnt++;
        total_cnt++; if (cnt1 !== 16'd5) $display("FAIL wrap_cnt16 got %0d want 5", cnt1); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_wrong_yumi();
        test_mid_reset();
        test_random();
        test_counter_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule
